// File: rtl/alu_issue_ctrl.sv
// Issue stage for the 16-bit four-op ALU: buffers commands, drives the ALU,
// captures results into an accumulator and a valid/ready result register.
module alu_issue_ctrl #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_a_acc,
    input  logic             cmd_b_acc,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_s,
    input  logic [WIDTH-1:0] alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [WIDTH-1:0] acc,
    output logic [15:0]      op_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [1:0]       op;
        logic             a_acc;
        logic             b_acc;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t state, state_nxt;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          empty, full;
    logic          push, pop, fire;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = fire;
    assign head      = mem[rptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= '{op: cmd_op, a_acc: cmd_a_acc, b_acc: cmd_b_acc,
                           a: cmd_a, b: cmd_b};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Operand muxing reads the live accumulator, so a dependent command
    // sees the previous result without a bubble.
    always_comb begin
        alu_a = '0;
        alu_b = '0;
        alu_s = '0;
        if (!empty) begin
            alu_a = head.a_acc ? acc : head.a;
            alu_b = head.b_acc ? acc : head.b;
            alu_s = head.op;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (push || !empty) state_nxt = RUN;
            end
            RUN: begin
                if (res_valid && !res_ready && !empty)
                    state_nxt = STALL;
                else if (empty && !push && (!res_valid || res_ready))
                    state_nxt = IDLE;
            end
            STALL: begin
                if (res_ready) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The stalled condition blocks fire on its own; a ready arriving while
    // in STALL lets the queued head issue in that same cycle.
    always_comb begin
        fire = 1'b0;
        if (state != IDLE)
            fire = !empty && (!res_valid || res_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            acc       <= '0;
            op_count  <= '0;
        end else begin
            if (fire) begin
                res_data  <= alu_out;
                acc       <= alu_out;
                res_valid <= 1'b1;
                op_count  <= op_count + 16'd1;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural four-op ALU
// (AND, NOT b, ADD, signed byte-wise saturating add) closing the loop.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic        cmd_a_acc;
    logic        cmd_b_acc;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [1:0]  alu_s;
    logic [15:0] alu_out;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [15:0] acc;
    logic [15:0] op_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.WIDTH(16), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a_acc (cmd_a_acc),
        .cmd_b_acc (cmd_b_acc),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s     (alu_s),
        .alu_out   (alu_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .acc       (acc),
        .op_count  (op_count)
    );

    function automatic logic [7:0] sat8(input logic [7:0] x, input logic [7:0] y);
        logic signed [8:0] s;
        s = $signed({x[7], x}) + $signed({y[7], y});
        if (s > 9'sd127)       return 8'h7F;
        else if (s < -9'sd128) return 8'h80;
        else                   return s[7:0];
    endfunction

    always_comb begin
        alu_out = '0;
        case (alu_s)
            2'd0: alu_out = alu_a & alu_b;
            2'd1: alu_out = ~alu_b;
            2'd2: alu_out = alu_a + alu_b;
            2'd3: alu_out = {sat8(alu_a[15:8], alu_b[15:8]),
                             sat8(alu_a[7:0], alu_b[7:0])};
            default: alu_out = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic v, input logic [1:0] op,
                           input logic aa, input logic ba,
                           input logic [15:0] a, input logic [15:0] b);
        cmd_valid = v;
        cmd_op    = op;
        cmd_a_acc = aa;
        cmd_b_acc = ba;
        cmd_a     = a;
        cmd_b     = b;
    endtask

    task automatic run_one(input string tag, input logic [1:0] op,
                           input logic aa, input logic ba,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp);
        int n;
        set_cmd(1'b1, op, aa, ba, a, b);
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 8) begin
            tick();
            n++;
        end
        chk({tag, "_data"}, res_data, exp);
        chk({tag, "_lat"}, n, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp4 [4];
        int pushes;
        int cyc;
        exp4 = '{16'h0001, 16'h0002, 16'h0004, 16'h0008};

        rst = 1'b1;
        res_ready = 1'b0;
        set_cmd(1'b0, 2'd0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_alu_s", alu_s, 0);

        // Fill FIFO with a pending result, then reset asynchronously.
        set_cmd(1'b1, 2'd2, 1'b0, 1'b0, 16'h0001, 16'h0002);
        repeat (5) tick();
        cmd_valid = 1'b0;
        chk("fill_cmd_ready", cmd_ready, 0);
        chk("fill_res_valid", res_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_res_valid", res_valid, 0);
        chk("arst_cmd_ready", cmd_ready, 1);
        chk("arst_alu", {alu_a, alu_b}, 0);
        chk("arst_alu_s", alu_s, 0);
        chk("arst_res_data", res_data, 0);
        chk("arst_acc", acc, 0);
        chk("arst_op_count", op_count, 0);
        chk("arst_fsm", 32'(dut.state), 0);
        @(negedge clk);
        rst = 1'b0;
        res_ready = 1'b1;
        tick();

        // AND then NOT, checking issue outputs before the fire edge.
        set_cmd(1'b1, 2'd0, 1'b0, 1'b0, 16'h0F0F, 16'hF0F0);
        tick();
        cmd_valid = 1'b0;
        chk("and_alu_a", alu_a, 16'h0F0F);
        chk("and_alu_b", alu_b, 16'hF0F0);
        chk("and_alu_s", alu_s, 0);
        tick();
        chk("and_valid", res_valid, 1);
        chk("and_data", res_data, 16'h0000);
        run_one("not", 2'd1, 1'b0, 1'b0, 16'h1234, 16'hCC77, 16'h3388);
        chk("opcnt_2", op_count, 2);

        run_one("add_wrap", 2'd2, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000);
        run_one("sat_mid", 2'd3, 1'b0, 1'b0, 16'hCCCC, 16'h6666, 16'h3232);
        run_one("sat_clip", 2'd3, 1'b0, 1'b0, 16'h7282, 16'h7282, 16'h7F80);
        chk("opcnt_5", op_count, 5);
        tick();

        // Accumulator chain issued back-to-back.
        for (int i = 0; i < 4; i++) begin
            if (i == 0) set_cmd(1'b1, 2'd2, 1'b0, 1'b0, 16'h0001, 16'h0000);
            else        set_cmd(1'b1, 2'd2, 1'b1, 1'b1, 16'hAAAA, 16'h5555);
            tick();
            if (i > 0) begin
                chk("chain_valid", res_valid, 1);
                chk("chain_data", res_data, exp4[i-1]);
            end
        end
        cmd_valid = 1'b0;
        tick();
        chk("chain_valid3", res_valid, 1);
        chk("chain_data3", res_data, exp4[3]);
        chk("chain_acc", acc, 16'h0008);
        chk("opcnt_9", op_count, 9);
        tick();
        chk("idle_valid", res_valid, 0);

        // Backpressure: one captured, DEPTH queued, then drain.
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_cmd(1'b1, 2'd2, 1'b0, 1'b0, 16'(i), 16'h1000);
            tick();
            if (i < 4) chk("bp_ready_hi", cmd_ready, 1);
            else       chk("bp_ready_lo", cmd_ready, 0);
            if (i == 2) chk("bp_fsm_stall", 32'(dut.state), 2);
        end
        cmd_valid = 1'b0;
        tick();
        chk("bp_hold_data", res_data, 16'h1000);
        chk("bp_hold_acc", acc, 16'h1000);
        chk("bp_hold_valid", res_valid, 1);
        res_ready = 1'b1;
        for (int j = 1; j < 5; j++) begin
            tick();
            chk("drain_valid", res_valid, 1);
            chk("drain_data", res_data, 16'h1000 + 16'(j));
            if (j == 1) chk("drain_ready", cmd_ready, 1);
        end
        tick();
        chk("drain_done", res_valid, 0);
        chk("opcnt_14", op_count, 14);
        tick();
        chk("back_idle", 32'(dut.state), 0);

        // op_count wrap.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        pushes = 0;
        cyc = 0;
        set_cmd(1'b1, 2'd3, 1'b0, 1'b0, 16'h0000, 16'h0000);
        while (pushes < 65535 && cyc < 70000) begin
            if (cmd_ready) pushes++;
            tick();
            cyc++;
        end
        cmd_valid = 1'b0;
        repeat (4) tick();
        chk("wrap_pushes", pushes, 65535);
        chk("wrap_ffff", op_count, 16'hFFFF);
        run_one("wrap_last", 2'd2, 1'b0, 1'b0, 16'h0003, 16'h0004, 16'h0007);
        chk("wrap_zero", op_count, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
